// File: rtl/cw_arb_pkg.sv
// Shared types and helpers for the codeword ROM arbiter.
package cw_arb_pkg;

    localparam int ROM_LAT_DEF = 4;

    // Tag fields are sized for the largest supported configuration
    // (up to 8 requesters, burst-length fields up to 8 bits wide).
    localparam int TAG_ID_W  = 3;
    localparam int TAG_IDX_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    typedef struct packed {
        logic                 vld;
        logic [TAG_ID_W-1:0]  id;
        logic [TAG_IDX_W-1:0] idx;
        logic                 last;
    } rsp_tag_t;

    // ROM addresses wrap at the ROM depth, not at the address-field width.
    function automatic int next_addr(input int cur, input int depth);
        return (cur == depth - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/cw_rr_arbiter.sv
// One-hot round-robin pick from a request vector and the last-winner pointer.
// Build option CW_ARB_PRIO_EN: requester 0 always wins when requesting and
// the remaining requesters share round-robin among themselves.
module cw_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  win_id,
    output logic            any
);

    logic [NREQ-1:0] pool;
    logic [NREQ-1:0] above;
    logic [NREQ-1:0] upper;
    logic [NREQ-1:0] pick;

    // Prefer requests above the pointer, else wrap to the lowest request.
    always_comb begin
        above = ~((NREQ'(2) << ptr) - NREQ'(1));
`ifdef CW_ARB_PRIO_EN
        pool  = req[0] ? NREQ'(1) : (req & ~NREQ'(1));
`else
        pool  = req;
`endif
        upper  = pool & above;
        pick   = (upper != '0) ? upper : pool;
        grant  = pick & (~pick + NREQ'(1));
        win_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) win_id = IDW'(i);
        end
        any = |req;
    end

endmodule

// File: rtl/cw_rom_arbiter.sv
// Shares one codeword ROM read port among NREQ requesters. Each grant becomes
// a burst of sequential ROM reads; returned words are tagged and realigned to
// the ROM latency. Build option CW_ARB_PRIO_EN gives requester 0 fixed priority.
module cw_rom_arbiter
    import cw_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = 1024,
    parameter int DEPTH   = 64,
    parameter int AW      = 7,
    parameter int LW      = 6,
    parameter int ROM_LAT = ROM_LAT_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ*AW-1:0]      i_req_addr,
    input  logic [NREQ*LW-1:0]      i_req_len,
    output logic [NREQ-1:0]         o_grant,
    output logic                    o_busy,
    output logic                    o_rom_rden,
    output logic [AW-1:0]           o_rom_addr,
    input  logic [DW-1:0]           i_rom_q,
    output logic                    o_rsp_valid,
    output logic [$clog2(NREQ)-1:0] o_rsp_id,
    output logic [LW-1:0]           o_rsp_idx,
    output logic                    o_rsp_last,
    output logic [DW-1:0]           o_rsp_data
);

    localparam int IDW = $clog2(NREQ);

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  ptr;
    logic [AW-1:0]   cur;
    logic [LW-1:0]   len;
    logic [LW-1:0]   beat;
    logic [IDW-1:0]  id;
    logic            take;

    logic [NREQ-1:0] arb_grant;
    logic [IDW-1:0]  win_id;
    logic            arb_any;
    logic [AW-1:0]   addr_sel;
    logic [LW-1:0]   len_sel;
    logic [AW-1:0]   start_addr;

    rsp_tag_t        tag_p0;
    rsp_tag_t        tag_pipe [ROM_LAT];
    logic            pipe_busy;

    cw_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req    (i_req),
        .ptr    (ptr),
        .grant  (arb_grant),
        .win_id (win_id),
        .any    (arb_any)
    );

    assign addr_sel   = i_req_addr[int'(win_id)*AW +: AW];
    assign len_sel    = i_req_len[int'(win_id)*LW +: LW];
    assign start_addr = (int'(addr_sel) >= DEPTH) ? AW'(DEPTH - 1) : addr_sel;

    assign o_rom_rden = (state == BURST);
    assign o_rom_addr = cur;
    assign o_busy     = (state != IDLE) || pipe_busy;

    // Next state and grant pulse; grant is suppressed while reset is asserted.
    always_comb begin
        state_nxt = state;
        o_grant   = '0;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any && !i_reset) begin
                    o_grant   = arb_grant;
                    take      = 1'b1;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (beat == len) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Burst bookkeeping: latch the winner's request, then step address and beat.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ptr  <= IDW'(NREQ - 1);
            cur  <= '0;
            len  <= '0;
            beat <= '0;
            id   <= '0;
        end else if (take) begin
            cur  <= start_addr;
            len  <= len_sel;
            beat <= '0;
            id   <= win_id;
`ifdef CW_ARB_PRIO_EN
            if (win_id != '0) ptr <= win_id;
`else
            ptr  <= win_id;
`endif
        end else if (state == BURST) begin
            cur  <= AW'(next_addr(int'(cur), DEPTH));
            beat <= beat + LW'(1);
        end
    end

    // Tag for the read issued this cycle.
    always_comb begin
        tag_p0.vld  = o_rom_rden;
        tag_p0.id   = TAG_ID_W'(id);
        tag_p0.idx  = TAG_IDX_W'(beat);
        tag_p0.last = (beat == len);
    end

    // Tag delay line matching the ROM read latency.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < ROM_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= tag_p0;
            for (int i = 1; i < ROM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // Any read still in flight keeps the block busy.
    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < ROM_LAT; i++) pipe_busy = pipe_busy | tag_pipe[i].vld;
    end

    // Response stage: ROM word joins its tag; data holds between valid beats.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= '0;
            o_rsp_idx   <= '0;
            o_rsp_last  <= 1'b0;
            o_rsp_data  <= '0;
        end else begin
            o_rsp_valid <= tag_pipe[ROM_LAT-1].vld;
            if (tag_pipe[ROM_LAT-1].vld) begin
                o_rsp_id   <= tag_pipe[ROM_LAT-1].id[IDW-1:0];
                o_rsp_idx  <= tag_pipe[ROM_LAT-1].idx[LW-1:0];
                o_rsp_last <= tag_pipe[ROM_LAT-1].last;
                o_rsp_data <= i_rom_q;
            end
        end
    end

endmodule

// File: tb/tb_cw_rom_arbiter.sv
// Bench for cw_rom_arbiter: directed scenarios plus random traffic, scored
// against a schedule-based model (grant -> list of expected reads/responses).
// Honours CW_ARB_PRIO_EN when the build defines it.
module tb_cw_rom_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 64;
    localparam int DEPTH   = 64;
    localparam int AW      = 7;
    localparam int LW      = 6;
    localparam int ROM_LAT = 4;
    localparam int IDW     = $clog2(NREQ);

    logic                 clk = 1'b0;
    logic                 i_reset;
    logic [NREQ-1:0]      i_req;
    logic [NREQ*AW-1:0]   i_req_addr;
    logic [NREQ*LW-1:0]   i_req_len;
    logic [NREQ-1:0]      o_grant;
    logic                 o_busy;
    logic                 o_rom_rden;
    logic [AW-1:0]        o_rom_addr;
    logic [DW-1:0]        i_rom_q;
    logic                 o_rsp_valid;
    logic [IDW-1:0]       o_rsp_id;
    logic [LW-1:0]        o_rsp_idx;
    logic                 o_rsp_last;
    logic [DW-1:0]        o_rsp_data;

    cw_rom_arbiter #(
        .NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .AW(AW), .LW(LW), .ROM_LAT(ROM_LAT)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .i_req_addr(i_req_addr),
        .i_req_len(i_req_len), .o_grant(o_grant), .o_busy(o_busy),
        .o_rom_rden(o_rom_rden), .o_rom_addr(o_rom_addr), .i_rom_q(i_rom_q),
        .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_idx(o_rsp_idx),
        .o_rsp_last(o_rsp_last), .o_rsp_data(o_rsp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rom_word(input int a);
        return {32'(a) * 32'h9E3779B1, 32'(a) ^ 32'hC0DE0000};
    endfunction

    // ROM model: data appears ROM_LAT cycles after the read; junk otherwise.
    logic [AW-1:0] rom_a [ROM_LAT];
    logic          rom_v [ROM_LAT];
    always @(posedge clk) begin
        rom_a[0] <= o_rom_addr;
        rom_v[0] <= o_rom_rden;
        for (int i = 1; i < ROM_LAT; i++) begin
            rom_a[i] <= rom_a[i-1];
            rom_v[i] <= rom_v[i-1];
        end
    end
    assign i_rom_q = rom_v[ROM_LAT-1] ? rom_word(int'(rom_a[ROM_LAT-1]))
                                      : ~rom_word(int'(rom_a[ROM_LAT-1]));

    typedef struct {
        int cyc;
        int addr;
        int id;
        int idx;
        bit last;
    } ev_t;

    ev_t             rdq[$];
    ev_t             rsq[$];
    int              n_total = 0;
    int              n_bad   = 0;
    int              cyc     = 0;
    int              busy_until = -1;
    int              grant_cyc  = -1;
    int              last_rden  = -1000;
    int              ptr        = NREQ - 1;
    int              m_win      = -1;
    logic [63:0]     last_data  = '0;
    logic [NREQ-1:0] pend;
    int              raddr [NREQ];
    int              rlen  [NREQ];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Winner by the arbitration rule: first request after the pointer, cyclically.
    function automatic int pick(input logic [NREQ-1:0] r);
        int c;
`ifdef CW_ARB_PRIO_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= NREQ; k++) begin
            c = (ptr + k) % NREQ;
`ifdef CW_ARB_PRIO_EN
            if (c == 0) continue;
`endif
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic tick(input logic rst);
        logic [NREQ-1:0] exp_grant;
        int              win;
        int              a;
        bit              bsy;
        ev_t             e;
        @(posedge clk);
        #1;
        for (int k = 0; k < NREQ; k++) begin
            i_req_addr[k*AW +: AW] = AW'(raddr[k]);
            i_req_len[k*LW +: LW]  = LW'(rlen[k]);
        end
        i_req   = pend;
        i_reset = rst;
        #1;
        win = -1;
        if (!rst && cyc > busy_until && pend != '0) win = pick(pend);
        exp_grant = '0;
        if (win >= 0) exp_grant[win] = 1'b1;
        check("grant", 64'(o_grant), 64'(exp_grant));
        bsy = (cyc > grant_cyc && cyc <= busy_until) || (cyc - last_rden <= ROM_LAT);
        check("busy", 64'(o_busy), 64'(bsy));
        if (rdq.size() != 0 && rdq[0].cyc == cyc) begin
            e = rdq.pop_front();
            check("rden", 64'(o_rom_rden), 64'(1));
            check("rom_addr", 64'(o_rom_addr), 64'(e.addr));
            last_rden = cyc;
        end else begin
            check("rden", 64'(o_rom_rden), 64'(0));
        end
        if (rsq.size() != 0 && rsq[0].cyc == cyc) begin
            e = rsq.pop_front();
            check("rsp_valid", 64'(o_rsp_valid), 64'(1));
            check("rsp_id", 64'(o_rsp_id), 64'(e.id));
            check("rsp_idx", 64'(o_rsp_idx), 64'(e.idx));
            check("rsp_last", 64'(o_rsp_last), 64'(e.last));
            check("rsp_data", o_rsp_data, rom_word(e.addr));
            last_data = rom_word(e.addr);
        end else begin
            check("rsp_valid", 64'(o_rsp_valid), 64'(0));
            check("rsp_hold", o_rsp_data, last_data);
        end
        if (win >= 0) begin
            a = (raddr[win] >= DEPTH) ? DEPTH - 1 : raddr[win];
            for (int k = 0; k <= rlen[win]; k++) begin
                e.cyc  = cyc + 1 + k;
                e.addr = (a + k) % DEPTH;
                e.id   = win;
                e.idx  = k;
                e.last = (k == rlen[win]);
                rdq.push_back(e);
                e.cyc  = cyc + 1 + k + ROM_LAT + 1;
                rsq.push_back(e);
            end
            busy_until = cyc + 1 + rlen[win];
            grant_cyc  = cyc;
`ifdef CW_ARB_PRIO_EN
            if (win != 0) ptr = win;
`else
            ptr = win;
`endif
            pend[win] = 1'b0;
        end
        if (rst) begin
            rdq.delete();
            rsq.delete();
            busy_until = -1;
            grant_cyc  = -1;
            last_rden  = -1000;
            ptr        = NREQ - 1;
            last_data  = '0;
        end
        m_win = win;
        cyc++;
    endtask

    task automatic wait_grant(input int k);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick(1'b0);
            if (m_win == k) got = 1'b1;
        end
        if (!got) check("grant_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        i_reset    = 1'b1;
        i_req      = '0;
        i_req_addr = '0;
        i_req_len  = '0;
        pend       = '0;
        for (int k = 0; k < NREQ; k++) begin
            raddr[k] = 0;
            rlen[k]  = 0;
        end
        repeat (3) @(posedge clk);
        repeat (3) tick(1'b0);

        // single burst from requester 1
        raddr[1] = 10; rlen[1] = 3; pend[1] = 1'b1;
        wait_grant(1);
        repeat (12) tick(1'b0);

        // all requesters contending with single-beat bursts
        for (int k = 0; k < NREQ; k++) begin
            raddr[k] = k * 5;
            rlen[k]  = 0;
        end
        repeat (24) begin
            pend = '1;
            tick(1'b0);
        end
        pend = '0;
        repeat (8) tick(1'b0);

        // address wrap at DEPTH, then clamp of an out-of-range start
        raddr[2] = 62; rlen[2] = 3; pend[2] = 1'b1;
        wait_grant(2);
        repeat (10) tick(1'b0);
        raddr[0] = 70; rlen[0] = 1; pend[0] = 1'b1;
        wait_grant(0);
        repeat (8) tick(1'b0);

        // reset during beat 2 of an 8-beat burst, then requester 0 vs 2
        raddr[1] = 20; rlen[1] = 7; pend[1] = 1'b1;
        wait_grant(1);
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        repeat (8) tick(1'b0);
        raddr[0] = 5; rlen[0] = 0; raddr[2] = 6; rlen[2] = 0;
        pend = 4'b0101;
        wait_grant(0);
        repeat (8) tick(1'b0);

        // requesters 0 and 2 held, then 2 and 3
        raddr[0] = 1; rlen[0] = 1; raddr[2] = 2; rlen[2] = 1; raddr[3] = 3; rlen[3] = 1;
        repeat (12) begin
            pend[0] = 1'b1;
            pend[2] = 1'b1;
            tick(1'b0);
        end
        pend = '0;
        repeat (12) begin
            pend[2] = 1'b1;
            pend[3] = 1'b1;
            tick(1'b0);
        end
        pend = '0;
        repeat (10) tick(1'b0);

        // requester 3 re-requesting immediately after each grant
        raddr[3] = 40; rlen[3] = 2;
        repeat (12) begin
            pend[3] = 1'b1;
            tick(1'b0);
        end
        pend = '0;
        repeat (10) tick(1'b0);

        // random traffic with occasional request drops and resets
        repeat (2000) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!pend[k] && $urandom_range(0, 3) == 0) begin
                    pend[k]  = 1'b1;
                    raddr[k] = int'($urandom_range(0, 127));
                    rlen[k]  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 63))
                                                            : int'($urandom_range(0, 5));
                end else if (pend[k] && $urandom_range(0, 31) == 0) begin
                    pend[k] = 1'b0;
                end
            end
            tick($urandom_range(0, 199) == 0);
        end
        pend = '0;
        repeat (80) tick(1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
